// File: rtl/dram_ctrl_pkg.sv
// Shared encodings for the DRAM command sequencer: PHY command opcodes,
// FSM states and page-policy selectors.
package dram_ctrl_pkg;

  localparam logic [2:0] CMD_ACT  = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_PRE  = 3'd3;
  localparam logic [2:0] CMD_PREA = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_NOP  = 3'd7;

  localparam int PAGE_OPEN   = 0;
  localparam int PAGE_CLOSED = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_COL,
    ST_REF_PREA,
    ST_REF
  } state_e;

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open bit and open-row table with a combinational open/hit lookup
// for one bank index.
module dram_bank_tracker #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 7,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              set_en,
  input  logic [BANK_W-1:0] set_bank,
  input  logic [ROW_W-1:0]  set_row,
  input  logic              clr_en,
  input  logic [BANK_W-1:0] clr_bank,
  input  logic              clr_all,
  input  logic [BANK_W-1:0] look_bank,
  input  logic [ROW_W-1:0]  look_row,
  output logic              look_open,
  output logic              look_hit,
  output logic              any_open
);

  logic [NUM_BANKS-1:0]            open_q;
  logic [NUM_BANKS-1:0][ROW_W-1:0] row_tbl;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      open_q  <= '0;
      row_tbl <= '0;
    end else if (clr_all) begin
      open_q <= '0;
    end else begin
      if (clr_en) open_q[clr_bank] <= 1'b0;
      if (set_en) begin
        open_q[set_bank]  <= 1'b1;
        row_tbl[set_bank] <= set_row;
      end
    end
  end

  assign look_open = open_q[look_bank];
  assign look_hit  = open_q[look_bank] && (row_tbl[look_bank] == look_row);
  assign any_open  = |open_q;

endmodule

// File: rtl/dram_cmd_sched_fsm.sv
// DRAM command sequencer: per-bank row tracking, BURST_LEN column beats per
// request, periodic PREA/REF. Optional counters under `DRAM_CTRL_STATS_EN`.
module dram_cmd_sched_fsm
  import dram_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_BANKS  = 8,
  parameter int NUMBER_OF_ROWS   = 128,
  parameter int NUMBER_OF_COLS   = 8,
  parameter int BURST_LEN        = 4,
  parameter int REFRESH_INTERVAL = 512,
  parameter int PAGE_POLICY      = 0,
  localparam int BANK_W = $clog2(NUMBER_OF_BANKS),
  localparam int ROW_W  = $clog2(NUMBER_OF_ROWS),
  localparam int COL_W  = $clog2(NUMBER_OF_COLS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              refresh_pending,
  output logic              busy
`ifdef DRAM_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
  output logic [15:0]       stat_refreshes
`endif
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int RCNT_W = $clog2(REFRESH_INTERVAL);

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   bank_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic                we_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                auto_pre_q;
  logic [RCNT_W-1:0]   rcnt_q;
  logic                pend_q;

  logic hs, accept, last_beat, row_hit;
  logic look_open, look_hit, any_open;

  assign req_ready = (state_q == ST_IDLE) && !pend_q && !rst_b;
  assign accept    = req_valid && req_ready;
  assign cmd_valid = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign hs        = cmd_valid && cmd_ready;
  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign row_hit   = look_hit && (PAGE_POLICY == PAGE_OPEN);
  assign cmd_bank  = bank_q;
  assign cmd_row   = row_q;
  assign cmd_col   = col_q;
  assign refresh_pending = pend_q;

  dram_bank_tracker #(.NUM_BANKS(NUMBER_OF_BANKS), .ROW_W(ROW_W)) u_trk (
    .clk       (clk),
    .rst_b     (rst_b),
    .set_en    (state_q == ST_ACT && hs),
    .set_bank  (bank_q),
    .set_row   (row_q),
    .clr_en    (state_q == ST_PRE && hs),
    .clr_bank  (bank_q),
    .clr_all   (state_q == ST_REF_PREA && hs),
    .look_bank (req_bank),
    .look_row  (req_row),
    .look_open (look_open),
    .look_hit  (look_hit),
    .any_open  (any_open)
  );

  always_comb begin
    state_d = state_q;
    cmd_op  = CMD_NOP;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (row_hit)        state_d = ST_COL;
          else if (look_open) state_d = ST_PRE;
          else                state_d = ST_ACT;
        end else if (pend_q) begin
          state_d = any_open ? ST_REF_PREA : ST_REF;
        end
      end
      ST_PRE: begin
        cmd_op = CMD_PRE;
        // auto_pre_q marks the closed-page precharge that ends a request
        if (hs) state_d = auto_pre_q ? ST_IDLE : ST_ACT;
      end
      ST_ACT: begin
        cmd_op = CMD_ACT;
        if (hs) state_d = ST_COL;
      end
      ST_COL: begin
        cmd_op = we_q ? CMD_WR : CMD_RD;
        if (hs && last_beat)
          state_d = (PAGE_POLICY == PAGE_CLOSED) ? ST_PRE : ST_IDLE;
      end
      ST_REF_PREA: begin
        cmd_op = CMD_PREA;
        if (hs) state_d = ST_REF;
      end
      ST_REF: begin
        cmd_op = CMD_REF;
        if (hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      auto_pre_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bank_q     <= req_bank;
        row_q      <= req_row;
        col_q      <= req_col;
        we_q       <= req_we;
        beat_q     <= '0;
        auto_pre_q <= 1'b0;
      end else if (state_q == ST_COL && hs) begin
        col_q  <= col_q + 1'b1;
        beat_q <= beat_q + 1'b1;
        if (last_beat) auto_pre_q <= 1'b1;
      end
    end
  end

  // Expiry wins over a same-cycle REF handshake so a fresh interval is never lost
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rcnt_q <= RCNT_W'(REFRESH_INTERVAL - 1);
      pend_q <= 1'b0;
    end else begin
      if (rcnt_q == '0) rcnt_q <= RCNT_W'(REFRESH_INTERVAL - 1);
      else              rcnt_q <= rcnt_q - 1'b1;
      if (rcnt_q == '0)                  pend_q <= 1'b1;
      else if (state_q == ST_REF && hs)  pend_q <= 1'b0;
    end
  end

`ifdef DRAM_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      stat_hits      <= '0;
      stat_misses    <= '0;
      stat_refreshes <= '0;
    end else begin
      if (accept && row_hit && stat_hits != 16'hFFFF)
        stat_hits <= stat_hits + 1'b1;
      if (accept && !row_hit && stat_misses != 16'hFFFF)
        stat_misses <= stat_misses + 1'b1;
      if (state_q == ST_REF && hs && stat_refreshes != 16'hFFFF)
        stat_refreshes <= stat_refreshes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_cmd_sched_fsm.sv
// Directed bench: instance 0 is open-page, instance 1 closed-page; expected
// command streams are hand-written from the command protocol.
module tb_dram_cmd_sched_fsm;

  localparam logic [2:0] ACT = 3'd0, RD = 3'd1, WR = 3'd2, PRE = 3'd3,
                         PREA = 3'd4, REF = 3'd5, NOP = 3'd7;

  logic       clk;
  logic       rst_b [2];
  logic       req_valid [2], req_ready [2], req_we [2];
  logic [2:0] req_bank [2];
  logic [6:0] req_row [2];
  logic [2:0] req_col [2];
  logic       cmd_valid [2], cmd_ready [2];
  logic [2:0] cmd_op [2], cmd_bank [2];
  logic [6:0] cmd_row [2];
  logic [2:0] cmd_col [2];
  logic       refresh_pending [2], busy [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dram_cmd_sched_fsm #(.PAGE_POLICY(0), .REFRESH_INTERVAL(512)) dut_o (
    .clk(clk), .rst_b(rst_b[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_bank(req_bank[0]), .req_row(req_row[0]), .req_col(req_col[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_bank(cmd_bank[0]), .cmd_row(cmd_row[0]), .cmd_col(cmd_col[0]),
    .refresh_pending(refresh_pending[0]), .busy(busy[0])
  );

  dram_cmd_sched_fsm #(.PAGE_POLICY(1), .REFRESH_INTERVAL(512)) dut_c (
    .clk(clk), .rst_b(rst_b[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_bank(req_bank[1]), .req_row(req_row[1]), .req_col(req_col[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_bank(cmd_bank[1]), .cmd_row(cmd_row[1]), .cmd_col(cmd_col[1]),
    .refresh_pending(refresh_pending[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Only the fields meaningful for an opcode take part in the comparison
  function automatic logic [31:0] pk(input logic v, input logic [2:0] op,
                                     input logic [2:0] b, input logic [6:0] r,
                                     input logic [2:0] c);
    logic [2:0] bb;
    logic [6:0] rr;
    logic [2:0] cc;
    bb = (op == ACT || op == RD || op == WR || op == PRE) ? b : 3'd0;
    rr = (op == ACT) ? r : 7'd0;
    cc = (op == RD || op == WR) ? c : 3'd0;
    return {15'd0, v, op, bb, rr, cc};
  endfunction

  function automatic logic [31:0] obs(input int d);
    return pk(cmd_valid[d], cmd_op[d], cmd_bank[d], cmd_row[d], cmd_col[d]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input int d, input string tag, input logic [2:0] op,
                         input logic [2:0] b, input logic [6:0] r, input logic [2:0] c);
    chk(tag, obs(d), pk(1'b1, op, b, r, c));
    step();
  endtask

  task automatic exp_idle(input int d, input string tag);
    chk(tag, {30'd0, cmd_valid[d], busy[d]}, 32'd0);
  endtask

  task automatic send_req(input int d, input logic we, input logic [2:0] b,
                          input logic [6:0] r, input logic [2:0] c);
    int n;
    req_we[d] = we; req_bank[d] = b; req_row[d] = r; req_col[d] = c;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("req_timeout", 32'd1, 32'd0);
    step();
    req_valid[d] = 1'b0;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst_b[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_bank[d] = '0; req_row[d] = '0; req_col[d] = '0; cmd_ready[d] = 1'b1;
    end
    #12;
    chk("rst_fields", {15'd0, cmd_bank[0], cmd_row[0], cmd_col[0]}, 32'd0);
    chk("rst_ctl", {25'd0, cmd_valid[0], cmd_op[0], refresh_pending[0], busy[0], req_ready[0]},
        {25'd0, 1'b0, NOP, 1'b0, 1'b0, 1'b0});
    step();
    rst_b[0] = 1'b0; rst_b[1] = 1'b0;
    #1;
    chk("rdy_after_rst", {31'd0, req_ready[0]}, 32'd1);

    // closed-page write, auto precharge, fresh ACT, then reset mid-burst
    send_req(1, 1'b1, 3'd7, 7'd0, 3'd0);
    exp_cmd(1, "cp_act", ACT, 3'd7, 7'd0, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(1, "cp_wr", WR, 3'd7, 7'd0, 3'(i));
    exp_cmd(1, "cp_pre", PRE, 3'd7, 7'd0, 3'd0);
    exp_idle(1, "cp_idle");
    send_req(1, 1'b1, 3'd7, 7'd0, 3'd0);
    exp_cmd(1, "cp_fresh_act", ACT, 3'd7, 7'd0, 3'd0);
    exp_cmd(1, "cp_wr2", WR, 3'd7, 7'd0, 3'd0);
    exp_cmd(1, "cp_wr2", WR, 3'd7, 7'd0, 3'd1);
    rst_b[1] = 1'b1;
    #1;
    chk("rst_mid", {27'd0, cmd_valid[1], cmd_op[1], busy[1]}, {27'd0, 1'b0, NOP, 1'b0});
    step();
    rst_b[1] = 1'b0;

    // closed bank: ACT then wrapping read burst
    send_req(0, 1'b0, 3'd2, 7'd5, 3'd6);
    exp_cmd(0, "rd_act", ACT, 3'd2, 7'd5, 3'd0);
    exp_cmd(0, "rd_c6", RD, 3'd2, 7'd0, 3'd6);
    exp_cmd(0, "rd_c7", RD, 3'd2, 7'd0, 3'd7);
    exp_cmd(0, "rd_c0", RD, 3'd2, 7'd0, 3'd0);
    exp_cmd(0, "rd_c1", RD, 3'd2, 7'd0, 3'd1);
    exp_idle(0, "rd_idle");

    // row hit: straight to column beats
    send_req(0, 1'b0, 3'd2, 7'd5, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(0, "hit_rd", RD, 3'd2, 7'd0, 3'(i));
    exp_idle(0, "hit_idle");

    // row miss: PRE, ACT, beats
    send_req(0, 1'b0, 3'd2, 7'd9, 3'd2);
    exp_cmd(0, "miss_pre", PRE, 3'd2, 7'd0, 3'd0);
    exp_cmd(0, "miss_act", ACT, 3'd2, 7'd9, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(0, "miss_rd", RD, 3'd2, 7'd0, 3'(2 + i));
    exp_idle(0, "miss_idle");

    // PHY stall on ACT
    cmd_ready[0] = 1'b0;
    send_req(0, 1'b1, 3'd3, 7'd7, 3'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_act", obs(0), pk(1'b1, ACT, 3'd3, 7'd7, 3'd0));
      step();
    end
    cmd_ready[0] = 1'b1;
    exp_cmd(0, "stall_rel", ACT, 3'd3, 7'd7, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(0, "stall_wr", WR, 3'd3, 7'd0, 3'(1 + i));
    exp_idle(0, "stall_idle");

    // refresh expiring while a burst is stalled
    cmd_ready[0] = 1'b0;
    send_req(0, 1'b0, 3'd4, 7'd1, 3'd0);
    n = 0;
    while (!refresh_pending[0] && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk("ref_timeout", 32'd1, 32'd0);
    chk("ref_hold", obs(0), pk(1'b1, ACT, 3'd4, 7'd1, 3'd0));
    chk("ref_rdy_low", {31'd0, req_ready[0]}, 32'd0);
    cmd_ready[0] = 1'b1;
    exp_cmd(0, "ref_act", ACT, 3'd4, 7'd1, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(0, "ref_rd", RD, 3'd4, 7'd0, 3'(i));
    chk("ref_gap", {29'd0, cmd_valid[0], refresh_pending[0], req_ready[0]}, 32'b010);
    step();
    chk("ref_pend_prea", {30'd0, refresh_pending[0], req_ready[0]}, 32'b10);
    exp_cmd(0, "ref_prea", PREA, 3'd0, 7'd0, 3'd0);
    chk("ref_pend_ref", {30'd0, refresh_pending[0], req_ready[0]}, 32'b10);
    exp_cmd(0, "ref_ref", REF, 3'd0, 7'd0, 3'd0);
    chk("ref_done", {29'd0, refresh_pending[0], cmd_valid[0], req_ready[0]}, 32'b001);

    // PREA closed every bank: former open row needs a new ACT
    send_req(0, 1'b0, 3'd2, 7'd9, 3'd0);
    exp_cmd(0, "post_ref_act", ACT, 3'd2, 7'd9, 3'd0);
    for (int i = 0; i < 4; i++) exp_cmd(0, "post_ref_rd", RD, 3'd2, 7'd0, 3'(i));
    exp_idle(0, "post_ref_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_cmd_sched_fsm.md
Name: dram_cmd_sched_fsm

Overview:
- Parametrised DRAM command sequencer; successor to the single-bank BNR/COL/PRECHARGE FSM.
- Sits between the address buffer (request side) and the DRAM command PHY (command side).
- Tracks the open row per bank and supports open-page or closed-page policy.
- Issues BURST_LEN column commands per request and schedules periodic refresh with precharge-all.
- Uses a valid/ready handshake on both sides.

Parameters:
NUMBER_OF_BANKS, 8, bank count (power of 2, >=2)
NUMBER_OF_ROWS, 128, rows per bank
NUMBER_OF_COLS, 8, columns per row (power of 2)
BURST_LEN, 4, column commands per request (1..NUMBER_OF_COLS)
REFRESH_INTERVAL, 512, clk cycles between refresh requests (>=16)
PAGE_POLICY, 0, 0=open-page, 1=closed-page (auto PRE after burst)

Ports:
clk  in  1  clock
rst_b  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_we  in  1  1=write, 0=read
req_bank  in  $clog2(NUMBER_OF_BANKS)  target bank
req_row  in  $clog2(NUMBER_OF_ROWS)  target row
req_col  in  $clog2(NUMBER_OF_COLS)  start column
cmd_valid  out  1  command present
cmd_ready  in  1  PHY accepts command
cmd_op  out  3  ACT=0 RD=1 WR=2 PRE=3 PREA=4 REF=5 NOP=7
cmd_bank  out  $clog2(NUMBER_OF_BANKS)  command bank
cmd_row  out  $clog2(NUMBER_OF_ROWS)  row (ACT)
cmd_col  out  $clog2(NUMBER_OF_COLS)  column (RD/WR)
refresh_pending  out  1  refresh owed, not yet issued
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_b=1, async): state IDLE; cmd_valid=0; cmd_op=NOP; cmd_bank/row/col=0; all bank-open bits 0; refresh counter=REFRESH_INTERVAL-1; refresh_pending=0; busy=0.
- req_ready is combinational: (state==IDLE)&&!refresh_pending&&!rst_b. On acceptance, bank, row, col and we are latched into registers.
- States: IDLE, PRE, ACT, COL, REF_PREA, REF.
- IDLE, request accepted:
  - open-page, bank open, row hit -> COL.
  - bank open, row miss -> PRE, then ACT, then COL.
  - bank closed -> ACT, then COL.
- IDLE with refresh_pending -> REF_PREA if any bank is open, else REF.
- Each command state:
  - Drives cmd_valid=1 with registered fields; first cmd_valid appears the cycle after acceptance.
  - Fields hold stable until cmd_ready; the transition happens on the cmd_valid&&cmd_ready cycle.
  - cmd_valid drops only if the next state issues nothing (IDLE).
  - Back-to-back commands are allowed with no bubble.
- PRE: clears the open bit of the latched bank.
- ACT: sets the open bit and the row table entry for that bank.
- COL:
  - Issues BURST_LEN RD/WR commands; cmd_col starts at req_col and increments modulo NUMBER_OF_COLS (wraps within the row, no row increment).
  - Beat counter advances only on handshake.
  - After the last beat: PAGE_POLICY=0 -> IDLE; PAGE_POLICY=1 -> PRE, then IDLE.
- REF_PREA: issues PREA and clears all open bits. REF then issues REF, clears refresh_pending, returns to IDLE.
- Refresh counter:
  - Free-running down-counter; at 0 it sets refresh_pending and reloads.
  - Expiry while pending: the flag stays set (no stacking).
  - Pending never interrupts a burst; it is serviced only from IDLE, i.e. after the current burst completes.
- Simultaneous req_valid and refresh expiry in IDLE: the request wins only if pending was 0 in that cycle (req_ready is computed from the registered flag).
- cmd_ready held 0 indefinitely: the FSM stalls, fields stay stable, and the refresh counter keeps running.
- Reset mid-operation: immediate return to reset values; open-row knowledge is discarded.

Optional Feature:
- Macro: DRAM_CTRL_STATS_EN.
- Defined: adds outputs stat_hits[15:0], stat_misses[15:0], stat_refreshes[15:0].
  - stat_hits: increments on row-hit acceptance.
  - stat_misses: increments on row-miss or closed-bank acceptance.
  - stat_refreshes: increments on REF handshake.
  - All saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dram_ctrl_pkg: cmd_op encodings (CMD_ACT..CMD_NOP), state encodings, PAGE_OPEN/PAGE_CLOSED constants.
- Sub-module dram_bank_tracker: per-bank open bit and row table. Provides set/clear/clear-all and combinational hit/open lookup for a bank index.

Test Plan:
- Read bank2 row5 col6, BURST_LEN=4, banks closed -> ACT(b2,r5), then RD cols 6,7,0,1 (wrap), then IDLE; busy low after the last handshake.
- Second read bank2 row5 col0, PAGE_POLICY=0 -> no ACT, RD cols 0..3 directly (hit).
- Read bank2 row9 after row5 open -> PRE(b2), ACT(b2,r9), then 4 RD.
- REFRESH_INTERVAL=16, a burst in progress at expiry -> burst completes, then PREA, REF; refresh_pending clears on the REF handshake; req_ready stays low meanwhile.
- cmd_ready held 0 for 10 cycles during ACT -> cmd_valid=1 and fields unchanged throughout; proceeds one cycle after cmd_ready=1.
- PAGE_POLICY=1 write bank7 row0 -> ACT, 4 WR, PRE(b7); a following request to bank7 row0 gets a fresh ACT. Assert rst_b mid-burst -> cmd_valid=0 immediately.
